// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchroniser followed by a counter-qualified
//                debounce FSM. Presents a clean level on dat_o, flags
//                aborted transitions on glitch_o and counts them in a
//                saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dat_i,
    output logic                dat_o,
    output logic                busy_o,
    output logic                glitch_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    // Last value of the stability counter before a WAIT state qualifies.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        WAIT_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_sync2;

    // Synchroniser, debounce FSM and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_state      <= ST_LOW;
            r_cnt        <= '0;
            dat_o        <= 1'b0;
            busy_o       <= 1'b0;
            glitch_o     <= 1'b0;
            glitch_cnt_o <= '0;
        end else begin
            r_sync1  <= dat_i;
            r_sync2  <= r_sync1;
            glitch_o <= 1'b0;

            case (r_state)
                ST_LOW: begin
                    if (r_sync2) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= c_CNT_ONE;
                        busy_o  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end

                WAIT_HIGH: begin
                    if (!r_sync2) begin
                        // Level fell back before qualifying: abort.
                        r_state  <= ST_LOW;
                        r_cnt    <= '0;
                        busy_o   <= 1'b0;
                        glitch_o <= 1'b1;
                        if (glitch_cnt_o != '1) begin
                            glitch_cnt_o <= glitch_cnt_o + 1'b1;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= '0;
                        busy_o  <= 1'b0;
                        dat_o   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end
                end

                ST_HIGH: begin
                    if (!r_sync2) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= c_CNT_ONE;
                        busy_o  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end

                WAIT_LOW: begin
                    if (r_sync2) begin
                        // Level rose back before qualifying: abort.
                        r_state  <= ST_HIGH;
                        r_cnt    <= '0;
                        busy_o   <= 1'b0;
                        glitch_o <= 1'b1;
                        if (glitch_cnt_o != '1) begin
                            glitch_cnt_o <= glitch_cnt_o + 1'b1;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                        busy_o  <= 1'b0;
                        dat_o   <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                    busy_o  <= 1'b0;
                    dat_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Bench for key_debounce. Three instances (default, narrow
//                glitch counter, minimum window) share one stimulus stream and
//                are checked every cycle against a run-length reference model,
//                plus directed scenarios with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    logic clk;
    logic rst;
    logic dat_in;

    logic [2:0] d_dat;
    logic [2:0] d_busy;
    logic [2:0] d_gl;
    logic [7:0] gc0;
    logic [1:0] gc1;
    logic [7:0] gc2;

    int n_checks;
    int n_errors;

    // Instance 0: defaults.
    key_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .GLITCH_W(8)) u0 (
        .clk_i(clk), .rst_i(rst), .dat_i(dat_in),
        .dat_o(d_dat[0]), .busy_o(d_busy[0]), .glitch_o(d_gl[0]), .glitch_cnt_o(gc0)
    );
    // Instance 1: 2-bit glitch counter for saturation.
    key_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .GLITCH_W(2)) u1 (
        .clk_i(clk), .rst_i(rst), .dat_i(dat_in),
        .dat_o(d_dat[1]), .busy_o(d_busy[1]), .glitch_o(d_gl[1]), .glitch_cnt_o(gc1)
    );
    // Instance 2: minimum window, counter exactly wide enough.
    key_debounce #(.DEBOUNCE_CYCLES(2), .CNT_W(1), .GLITCH_W(8)) u2 (
        .clk_i(clk), .rst_i(rst), .dat_i(dat_in),
        .dat_o(d_dat[2]), .busy_o(d_busy[2]), .glitch_o(d_gl[2]), .glitch_cnt_o(gc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int get_gc(input int i);
        case (i)
            0:       return int'(gc0);
            1:       return int'(gc1);
            default: return int'(gc2);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is described by its stable level and the length of the
    // current run of synchronised samples that disagree with it.
    int dc[3]   = '{4, 4, 2};
    int gmax[3] = '{255, 3, 255};
    int m_s1[3], m_s2[3], m_lvl[3], m_run[3], m_gl[3], m_gc[3];

    initial begin : compare
        logic r, d;
        int   s;
        forever begin
            @(posedge clk);
            r = rst;
            d = dat_in;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (r) begin
                    m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
                    m_run[i] = 0; m_gl[i] = 0; m_gc[i] = 0;
                end else begin
                    s = m_s2[i];
                    m_gl[i] = 0;
                    if (s != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == dc[i]) begin
                            m_lvl[i] = s;
                            m_run[i] = 0;
                        end
                    end else begin
                        if (m_run[i] > 0) begin
                            m_gl[i] = 1;
                            if (m_gc[i] < gmax[i]) m_gc[i]++;
                        end
                        m_run[i] = 0;
                    end
                    m_s2[i] = m_s1[i];
                    m_s1[i] = int'(d);
                end
                chk($sformatf("u%0d.dat_o", i),        int'(d_dat[i]),  m_lvl[i]);
                chk($sformatf("u%0d.busy_o", i),       int'(d_busy[i]), (m_run[i] > 0) ? 1 : 0);
                chk($sformatf("u%0d.glitch_o", i),     int'(d_gl[i]),   m_gl[i]);
                chk($sformatf("u%0d.glitch_cnt_o", i), get_gc(i),       m_gc[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Apply inputs for one edge; returns once that edge's outputs are settled.
    task automatic tick(input logic r, input logic d);
        rst    = r;
        dat_in = d;
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int pulses;
        int len;
        logic v;
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        dat_in = 1'b0;

        // Reset held with input high: everything stays zero.
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1);
            chk("rst.dat",  int'(d_dat[0]),  0);
            chk("rst.busy", int'(d_busy[0]), 0);
            chk("rst.gc",   int'(gc0),       0);
        end

        // Clean rise: edge 0 is the first post-reset capture.
        for (int e = 0; e <= 5; e++) begin
            tick(1'b0, 1'b1);
            if (e == 1) chk("rise.busy_e1", int'(d_busy[0]), 0);
            if (e == 2) chk("rise.busy_e2", int'(d_busy[0]), 1);
            if (e == 2) chk("rise.min_e2",  int'(d_dat[2]),  0);
            if (e == 3) chk("rise.min_e3",  int'(d_dat[2]),  1);
            if (e == 4) chk("rise.dat_e4",  int'(d_dat[0]),  0);
            if (e == 5) chk("rise.dat_e5",  int'(d_dat[0]),  1);
            if (e == 5) chk("rise.busy_e5", int'(d_busy[0]), 0);
        end
        repeat (3) tick(1'b0, 1'b1);

        // Clean fall, mirrored timing.
        for (int e = 0; e <= 5; e++) begin
            tick(1'b0, 1'b0);
            if (e == 2) chk("fall.busy_e2", int'(d_busy[0]), 1);
            if (e == 4) chk("fall.dat_e4",  int'(d_dat[0]),  1);
            if (e == 5) chk("fall.dat_e5",  int'(d_dat[0]),  0);
        end
        repeat (3) tick(1'b0, 1'b0);

        // Bounce: high 3, low 1, then high steadily.
        for (int e = 0; e <= 10; e++) begin
            tick(1'b0, (e == 3) ? 1'b0 : 1'b1);
            if (e == 4) chk("bounce.gl_e4", int'(d_gl[0]), 0);
            if (e == 5) chk("bounce.gl_e5", int'(d_gl[0]), 1);
            if (e == 5) chk("bounce.gc_e5", int'(gc0),     1);
            if (e == 6) chk("bounce.gl_e6", int'(d_gl[0]), 0);
            if (e == 8) chk("bounce.dat_e8", int'(d_dat[0]), 0);
            if (e == 9) chk("bounce.dat_e9", int'(d_dat[0]), 1);
        end

        // Return low and settle.
        repeat (10) tick(1'b0, 1'b0);

        // Saturation on the 2-bit counter: five 2-cycle pulses, 6 low between.
        pulses = 0;
        for (int p = 0; p < 5; p++) begin
            for (int e = 0; e < 8; e++) begin
                tick(1'b0, (e < 2) ? 1'b1 : 1'b0);
                if (d_gl[1]) pulses++;
                if (d_dat[1]) chk("sat.dat_low", int'(d_dat[1]), 0);
            end
        end
        repeat (4) begin
            tick(1'b0, 1'b0);
            if (d_gl[1]) pulses++;
        end
        chk("sat.pulses", pulses,    5);
        chk("sat.gc",     int'(gc1), 3);

        // Reset mid-wait in WAIT_LOW.
        repeat (8) tick(1'b0, 1'b1);
        chk("midrst.pre_dat", int'(d_dat[0]), 1);
        repeat (3) tick(1'b0, 1'b0);
        chk("midrst.busy", int'(d_busy[0]), 1);
        tick(1'b1, 1'b0);
        chk("midrst.dat",  int'(d_dat[0]),  0);
        chk("midrst.busy0", int'(d_busy[0]), 0);
        chk("midrst.gl",   int'(d_gl[0]),   0);
        chk("midrst.gc",   int'(gc0),       0);
        repeat (4) tick(1'b0, 1'b0);

        // Minimum window: 2-cycle pulse passes for exactly 2 cycles.
        for (int e = 0; e < 8; e++) begin
            tick(1'b0, (e < 2) ? 1'b1 : 1'b0);
            chk($sformatf("minwin.dat_e%0d", e), int'(d_dat[2]), (e == 3 || e == 4) ? 1 : 0);
        end
        // 1-cycle pulse: glitch, no output change.
        for (int e = 0; e < 6; e++) begin
            tick(1'b0, (e == 0) ? 1'b1 : 1'b0);
            chk($sformatf("minpulse.dat_e%0d", e), int'(d_dat[2]), 0);
            chk($sformatf("minpulse.gl_e%0d", e),  int'(d_gl[2]),  (e == 3) ? 1 : 0);
        end

        // Randomised runs of random length with occasional resets.
        repeat (800) begin
            len = $urandom_range(1, 7);
            v   = 1'($urandom_range(0, 1));
            repeat (len) tick(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
# key_debounce

Input conditioning stage that sits directly upstream of the edge detector. It takes a raw, asynchronous, bouncing level (push-button, mechanical switch, slow external strobe) and synchronises it into the clock domain. It then filters it with a counter-based stability window. It presents a clean, single-clock-domain level on `dat_o`, which the edge detector consumes on its data input to produce rise and fall pulses. Aborted transitions (bounces) are flagged and counted for board bring-up diagnostics.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4. Number of consecutive synchronised samples of the new level required before `dat_o` changes. Legal range is 2 to 2^`CNT_W`.
- `CNT_W`, default 20. Width of the stability counter.
- `GLITCH_W`, default 8. Width of the saturating glitch counter.

Ports:
- `clk_i`: input, 1 bit. The single clock. All logic is on the rising edge.
- `rst_i`: input, 1 bit. Reset is synchronous and active-high.
- `dat_i`: input, 1 bit. Raw asynchronous level.
- `dat_o`: output, 1 bit. Debounced level. Feeds the edge detector.
- `busy_o`: output, 1 bit. High while a candidate transition is being qualified.
- `glitch_o`: output, 1 bit. One-cycle pulse when a candidate transition is aborted.
- `glitch_cnt_o`: output, `GLITCH_W` bits. Saturating count of aborted transitions.

## Operation
- Synchroniser: two flops, `sync1 <= dat_i` and `sync2 <= sync1`. Only `sync2` (called `s` below) feeds the FSM.
- FSM states: `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`. All transitions are evaluated at the rising clock edge.
- `ST_LOW`:
  - If `s` = 1, go to `WAIT_HIGH` and set `cnt` = 1.
  - Otherwise stay, with `cnt` = 0.
- `WAIT_HIGH`:
  - If `s` = 0, go to `ST_LOW`, set `cnt` = 0 and pulse `glitch_o`.
  - Otherwise, if `cnt` = `DEBOUNCE_CYCLES`-1, go to `ST_HIGH` and set `cnt` = 0.
  - Otherwise increment `cnt`.
- `ST_HIGH` and `WAIT_LOW`: mirror images of `ST_LOW` and `WAIT_HIGH`, with `s` inverted. The qualified exit from `WAIT_LOW` goes to `ST_LOW`.
- The qualification requirement is therefore that `s` holds the new level for exactly `DEBOUNCE_CYCLES` consecutive samples. The sample that caused entry into a WAIT state counts as the first.
- Registered outputs:
  - `dat_o` is 1 in `ST_HIGH` and `WAIT_LOW`, and 0 in `ST_LOW` and `WAIT_HIGH`. It changes only on a qualified transition, so a glitch never toggles it.
  - `busy_o` is 1 in the WAIT states.
  - `glitch_o` is high for exactly the one cycle following the edge at which the abort is taken.
  - `glitch_cnt_o` increments by 1 on each abort and saturates at all-ones. It is not cleared except by `rst_i`.
- Width rule: `cnt` is `CNT_W` bits and never exceeds `DEBOUNCE_CYCLES`-1, so it never wraps.
- Reset (`rst_i` high at an edge), including mid-qualification:
  - `sync1` = `sync2` = 0.
  - State = `ST_LOW`, `cnt` = 0.
  - `dat_o` = 0, `busy_o` = 0, `glitch_o` = 0, `glitch_cnt_o` = 0.
  - A pending transition is discarded with no glitch pulse. Reset has priority over every other event.
- Abort versus qualification: an abort and a qualification cannot occur in the same cycle. An abort requires `s` to be at the old level, a qualification requires the new level.
- Re-entry: after an abort the FSM is back in its stable state. The next opposite sample restarts the window at `cnt` = 1, so there is no dead time.

## Timing
- Latency: if `dat_i` is first captured high at edge 0 and held, the FSM enters `WAIT_HIGH` after edge 2 and `dat_o` rises after edge `DEBOUNCE_CYCLES`+1. The same rule applies to falls.
- Pulse width: a `dat_i` pulse captured on fewer than `DEBOUNCE_CYCLES` consecutive edges never reaches `dat_o`.
- `busy_o`: asserts on the edge that enters a WAIT state. It deasserts on the edge that qualifies or aborts.
- Glitch reporting: `glitch_o` and the `glitch_cnt_o` increment appear together, one edge after the offending `s` sample.
- Combinational paths: none from `dat_i` to any output. The minimum input-to-output delay is 3 edges, with `DEBOUNCE_CYCLES` = 2.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 unless stated.
- Reset: hold `rst_i` high for 3 cycles with `dat_i` = 1 → all outputs 0 throughout. After release, `dat_o` rises after edge 5 counted from the first post-reset capture.
- Clean step: `dat_i` goes 0→1 and is held → `busy_o` is high after edges 2–4 and `dat_o` = 1 after edge 5. Then a 1→0 step gives the mirrored timing and `dat_o` = 0 after edge 5.
- Bounce: `dat_i` goes high for 3 cycles, low for 1, then high steadily → one `glitch_o` pulse and `glitch_cnt_o` = 1. `dat_o` rises 5 edges after the final rise is first captured.
- Saturation: with `GLITCH_W` = 2, apply five 2-cycle high pulses separated by 6 low cycles → `glitch_o` pulses 5 times, `glitch_cnt_o` sticks at 3 and `dat_o` stays 0.
- Reset mid-wait: assert `rst_i` while `busy_o` = 1 in `WAIT_LOW` → next cycle `dat_o` = 0, `busy_o` = 0, `glitch_o` = 0 and `glitch_cnt_o` = 0.
- Minimum window: with `DEBOUNCE_CYCLES` = 2, a 2-cycle high pulse → `dat_o` is high for exactly 2 cycles starting after edge 3. A 1-cycle pulse → a glitch and no `dat_o` change.
